// File: rtl/eth_tx_frame_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | eth_tx_frame_arbiter_pkg                                               |
// | Shared FSM state encoding and sizing helper for the TX frame arbiter.  |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
package eth_tx_frame_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PASS  = 2'd1,
        ST_ABORT = 2'd2,
        ST_DRAIN = 2'd3
    } arb_state_t;

    localparam logic [7:0] C_ABORT_DATA = 8'h00;

    // Returns ceil(log2(value)); 0 for value <= 1.
    function automatic int clog2_f(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/eth_tx_frame_arbiter_rr_select.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_priority_select                                                     |
// | Combinational round-robin picker: first requester above 'last'.        |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
module rr_priority_select
    import eth_tx_frame_arbiter_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = clog2_f(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  pick,
    output logic          valid
);

    logic [IW-1:0] w_idx;
    int            w_sum;

    // Walk (last+1) .. (last+N) modulo N; the port that just won is checked last.
    always_comb begin
        pick  = '0;
        valid = 1'b0;
        w_idx = '0;
        w_sum = 0;
        for (int k = 1; k <= N; k++) begin
            w_sum = int'(last) + k;
            if (w_sum >= N) begin
                w_sum = w_sum - N;
            end
            w_idx = IW'(w_sum);
            if (!valid && req[w_idx]) begin
                pick[w_idx] = 1'b1;
                valid       = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/eth_tx_frame_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | eth_tx_frame_arbiter                                                   |
// | Frame-atomic round-robin mux of N AXI-Stream sources onto the MAC TX.  |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
module eth_tx_frame_arbiter
    import eth_tx_frame_arbiter_pkg::*;
#(
    parameter int C_NUM_PORTS     = 2,
    parameter int C_STALL_TIMEOUT = 256
) (
    input  logic                       gtx_clk,
    input  logic                       gtx_rst,
    input  logic [8*C_NUM_PORTS-1:0]   s_axis_tdata,
    input  logic [C_NUM_PORTS-1:0]     s_axis_tvalid,
    input  logic [C_NUM_PORTS-1:0]     s_axis_tlast,
    input  logic [C_NUM_PORTS-1:0]     s_axis_tuser,
    output logic [C_NUM_PORTS-1:0]     s_axis_tready,
    output logic [7:0]                 m_axis_tdata,
    output logic                       m_axis_tvalid,
    output logic                       m_axis_tlast,
    output logic                       m_axis_tuser,
    input  logic                       m_axis_tready,
    output logic [C_NUM_PORTS-1:0]     grant,
    output logic                       abort
);

    localparam int IW = clog2_f(C_NUM_PORTS);
    localparam int CW = (C_STALL_TIMEOUT > 0) ? clog2_f(C_STALL_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] C_STALL_MAX   = '1;
    localparam logic [CW-1:0] C_STALL_LIMIT = CW'(C_STALL_TIMEOUT);

    arb_state_t             r_state;
    logic [C_NUM_PORTS-1:0] r_grant;
    logic [IW-1:0]          r_last;
    logic [CW-1:0]          r_stall;
    logic                   r_abort;

    logic [C_NUM_PORTS-1:0] w_pick;
    logic                   w_pick_valid;
    logic [IW-1:0]          w_pick_idx;
    logic [7:0]             w_port_data [C_NUM_PORTS];
    logic [7:0]             w_src_data;
    logic                   w_src_valid;
    logic                   w_src_last;
    logic                   w_src_user;
    logic [CW-1:0]          w_stall_inc;
    logic                   w_expire;

    generate
        for (genvar gi = 0; gi < C_NUM_PORTS; gi++) begin : g_unpack
            assign w_port_data[gi] = s_axis_tdata[8*gi +: 8];
        end
    endgenerate

    rr_priority_select #(
        .N  (C_NUM_PORTS),
        .IW (IW)
    ) u_rr_select (
        .req   (s_axis_tvalid),
        .last  (r_last),
        .pick  (w_pick),
        .valid (w_pick_valid)
    );

    always_comb begin
        w_pick_idx = '0;
        for (int i = 0; i < C_NUM_PORTS; i++) begin
            if (w_pick[i]) begin
                w_pick_idx = IW'(i);
            end
        end
    end

    // r_last always names the current owner while a frame is in flight.
    assign w_src_data  = w_port_data[r_last];
    assign w_src_valid = s_axis_tvalid[r_last];
    assign w_src_last  = s_axis_tlast[r_last];
    assign w_src_user  = s_axis_tuser[r_last];

    assign w_stall_inc = (r_stall == C_STALL_MAX) ? r_stall : r_stall + CW'(1);
    assign w_expire    = (C_STALL_TIMEOUT != 0) && (w_stall_inc == C_STALL_LIMIT);

    always_comb begin
        s_axis_tready = '0;
        m_axis_tdata  = 8'h00;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = 1'b0;
        case (r_state)
            ST_PASS: begin
                m_axis_tdata          = w_src_data;
                m_axis_tvalid         = w_src_valid;
                m_axis_tlast          = w_src_last;
                m_axis_tuser          = w_src_user;
                s_axis_tready[r_last] = m_axis_tready;
            end
            ST_ABORT: begin
                m_axis_tdata  = C_ABORT_DATA;
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = 1'b1;
                m_axis_tuser  = 1'b1;
            end
            ST_DRAIN: begin
                s_axis_tready[r_last] = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge gtx_clk) begin
        if (gtx_rst) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_last  <= IW'(C_NUM_PORTS - 1);
            r_stall <= '0;
            r_abort <= 1'b0;
        end else begin
            r_abort <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_valid) begin
                        r_grant <= w_pick;
                        r_last  <= w_pick_idx;
                        r_stall <= '0;
                        r_state <= ST_PASS;
                    end
                end
                ST_PASS: begin
                    if (w_src_valid) begin
                        r_stall <= '0;
                        if (m_axis_tready && w_src_last) begin
                            r_grant <= '0;
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_stall <= w_stall_inc;
                        if (w_expire) begin
                            r_abort <= 1'b1;
                            r_state <= ST_ABORT;
                        end
                    end
                end
                ST_ABORT: begin
                    if (m_axis_tready) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_src_valid && w_src_last) begin
                        r_grant <= '0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign grant = r_grant;
    assign abort = r_abort;

endmodule
`default_nettype wire
